keypad_entry: RTL and testbench
===============================

# keypad_entry

Input-side counterpart of the six-digit seven-segment display driver: scans a 4x4 active-low matrix keypad, debounces it, and assembles up to six decimal digits with an optional decimal point and sign. On Enter it converts the BCD buffer to binary. It presents `bin`/`dot`/`neg` in exactly the encoding the display driver consumes, so the two blocks connect directly.

## Interface
- `SCAN_N`, 16'd49_999: clock cycles per scan tick minus one (1 ms at 50 MHz).
- `DEB_N`, 4'd10: consecutive identical scan frames (1 frame = 4 ticks) required to accept a press or a release.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `row`  in  4  keypad rows, active-low, externally pulled up.
- `col`  out  4  keypad column drive, active-low, exactly one bit low at a time.
- `bin`  out  20  committed magnitude, 0..999_999.
- `dot`  out  6  committed decimal-point one-hot; bit k = point after digit k (digit 0 = least significant); 0 = no point.
- `neg`  out  1  committed sign; 1 = negative.
- `valid`  out  1  one-cycle pulse when `bin`/`dot`/`neg` update.
- `busy`  out  1  high while the BCD-to-binary conversion runs.

## Operation
- Key codes: row r (0..3) and driven column c (0..3) give code = 4r+c. Codes 0-9 are digits, A = point, B = sign toggle, C = clear, D = backspace, E = enter. F is ignored.
- Scan: a tick counter runs 0..`SCAN_N`. On wrap, the block samples `row` for the current column, then rotates `col` 1110→1101→1011→0111→1110. A frame is 4 ticks.
- Frame result: exactly one low row across the whole frame gives that key. Zero or multiple lows give "none".
- Debounce FSM:
  - RELEASED → PRESS_DEB when the frame has a key.
  - PRESS_DEB → HELD after `DEB_N` identical key frames. Entering HELD emits one `key_evt` with `key_code`.
  - PRESS_DEB → RELEASED on any differing frame.
  - HELD → REL_DEB on a "none" frame; REL_DEB → HELD on a key frame.
  - REL_DEB → RELEASED after `DEB_N` consecutive "none" frames.
  - There is no auto-repeat.
- Entry buffer: six BCD nibbles `d[5:0]`, a count `cnt` (0..6), a point mask `pm[5:0]`, and a sign flag `sg`.
  - Digit with `cnt`<6: `d` shifts up one nibble, new digit goes into `d[0]`, `pm` shifts left, `cnt`++. Ignored when `cnt`==6.
  - A: sets `pm`=000001 if `cnt`>0 and `pm`==0. Otherwise ignored.
  - B: `sg` toggles.
  - C: `d`, `pm`, `cnt` and `sg` all go to 0. Committed outputs are not changed.
  - D: if `cnt`>0, `d` shifts down one nibble, `pm` shifts right (a bit in position 0 is dropped), `cnt`--.
  - E: enters CONV.
- Entry FSM: ENTRY → CONV → DONE → ENTRY.
  - CONV runs 6 cycles, MSD first: `acc` = `acc`*10 + `d[5-i]`, using a 20-bit `acc` computed as (`acc`<<3)+(`acc`<<1)+digit. Overflow is impossible.
  - DONE loads `bin`=`acc` and `dot`=`pm`. It loads `neg`=`sg` AND (`acc`!=0), so minus zero is forced positive. It pulses `valid` and clears the buffer.
  - `key_evt` arriving in CONV or DONE is dropped.

## Timing
- Reset values: `col`=1110, `bin`=0, `dot`=0, `neg`=0, `valid`=0, `busy`=0. The tick counter, debounce FSM, buffer and entry FSM all go to their zero or idle state.
- `key_evt` to buffer update: 1 cycle.
- E `key_evt` to `valid`: 8 cycles (1 into CONV, 6 CONV, 1 DONE). `busy` is high for exactly the 6 CONV cycles. `valid` is asserted in the cycle after `busy` falls.
- Minimum press latency: `DEB_N` frames, i.e. `DEB_N`·4·(`SCAN_N`+1) cycles after the first stable frame.
- Reset asserted mid-CONV: conversion is abandoned, no `valid`, and outputs return to reset values in the next cycle.
- A key held through a conversion produces no second event.

## Structure
- Package `keypad_pkg` holds:
  - key code constants (`KEY_DOT`, `KEY_NEG`, `KEY_CLR`, `KEY_BS`, `KEY_ENT`);
  - the debounce state enum (RELEASED, PRESS_DEB, HELD, REL_DEB);
  - the entry state enum (ENTRY, CONV, DONE).
- Sub-module `key_scan` holds the tick counter, column drive, frame decode and debounce FSM. Its outputs are `key_evt` and `key_code[3:0]`.
- The top level holds the entry buffer, the conversion and the output registers.

## Test plan
Use `SCAN_N`=3 and `DEB_N`=2 in simulation.
- Keys 1,2,3,E → `bin`=123, `dot`=0, `neg`=0, one `valid` pulse 8 cycles after the E event.
- Keys 1,A,5,B,E → `bin`=15, `dot`=000010, `neg`=1.
- Keys 1..7 then E → seventh ignored; `bin`=123456. Then B,E with an empty buffer → `bin`=0, `neg`=0.
- Keys 4,A,2,D,D,9,E → `bin`=9, `dot`=0.
- Row glitch lasting 1 frame, then a two-key chord → no `key_evt`. Holding 5 for 20 frames → exactly one event.
- Assert `rst` in the 3rd CONV cycle after 9,9,E → no `valid`; `bin`=0 and `col`=1110 the next cycle.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared key codes and state encodings for the keypad entry block.
package keypad_pkg;

  localparam logic [3:0] KEY_DOT = 4'hA;
  localparam logic [3:0] KEY_NEG = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_BS  = 4'hD;
  localparam logic [3:0] KEY_ENT = 4'hE;

  typedef enum logic [1:0] {
    StReleased,
    StPressDeb,
    StHeld,
    StRelDeb
  } deb_state_e;

  typedef enum logic [1:0] {
    StEntry,
    StConv,
    StDone
  } entry_state_e;

endpackage

// File: rtl/keypad_entry_scan.sv
// Keypad column scanner, per-frame key decode and press/release debouncer.
module key_scan
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_N = 16'd49_999,
  parameter logic [3:0]  DEB_N  = 4'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_evt,
  output logic [3:0] key_code
);

  logic [3:0]  row_s1_q, row_s2_q;
  logic [15:0] tick_q;
  logic [1:0]  ci_q;
  logic [1:0]  lows_q;  // saturating count of low rows seen so far this frame
  logic [3:0]  fcode_q;
  logic        tick_wrap, frame_done, frame_key;
  logic [2:0]  s_cnt, lows_tot;
  logic [1:0]  s_row, lows_sat;
  logic [3:0]  code_now;

  deb_state_e st_q, st_d;
  logic [3:0] cnt_q, cnt_d, code_q, code_d;
  logic       evt_q, evt_d;
  logic [4:0] cnt_inc;

  assign tick_wrap  = (tick_q == SCAN_N);
  assign frame_done = tick_wrap && (ci_q == 2'd3);
  assign col        = ~(4'b0001 << ci_q);

  always_comb begin
    s_cnt = 3'd0;
    s_row = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!row_s2_q[i]) begin
        s_cnt = s_cnt + 3'd1;
        s_row = 2'(i);
      end
    end
    lows_tot  = {1'b0, lows_q} + s_cnt;
    lows_sat  = (lows_tot >= 3'd2) ? 2'd2 : lows_tot[1:0];
    frame_key = (lows_sat == 2'd1);
    code_now  = (s_cnt == 3'd1) ? {s_row, ci_q} : fcode_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      tick_q   <= '0;
      ci_q     <= '0;
      lows_q   <= '0;
      fcode_q  <= '0;
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
      tick_q   <= tick_wrap ? '0 : tick_q + 16'd1;
      if (tick_wrap) begin
        ci_q <= ci_q + 2'd1;
        if (ci_q == 2'd3) begin
          lows_q  <= '0;
          fcode_q <= '0;
        end else begin
          lows_q  <= lows_sat;
          fcode_q <= code_now;
        end
      end
    end
  end

  assign cnt_inc = {1'b0, cnt_q} + 5'd1;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    code_d = code_q;
    evt_d  = 1'b0;
    if (frame_done) begin
      unique case (st_q)
        StReleased: begin
          if (frame_key) begin
            code_d = code_now;
            if (DEB_N <= 4'd1) begin
              st_d  = StHeld;
              evt_d = 1'b1;
            end else begin
              st_d  = StPressDeb;
              cnt_d = 4'd1;
            end
          end
        end
        StPressDeb: begin
          if (frame_key && (code_now == code_q)) begin
            if (cnt_inc >= {1'b0, DEB_N}) begin
              st_d  = StHeld;
              evt_d = 1'b1;
            end else begin
              cnt_d = cnt_inc[3:0];
            end
          end else begin
            st_d = StReleased;
          end
        end
        StHeld: begin
          if (!frame_key) begin
            if (DEB_N <= 4'd1) begin
              st_d = StReleased;
            end else begin
              st_d  = StRelDeb;
              cnt_d = 4'd1;
            end
          end
        end
        StRelDeb: begin
          if (frame_key) begin
            st_d = StHeld;
          end else if (cnt_inc >= {1'b0, DEB_N}) begin
            st_d = StReleased;
          end else begin
            cnt_d = cnt_inc[3:0];
          end
        end
        default: st_d = StReleased;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= StReleased;
      cnt_q  <= '0;
      code_q <= '0;
      evt_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      code_q <= code_d;
      evt_q  <= evt_d;
    end
  end

  assign key_evt  = evt_q;
  assign key_code = code_q;

endmodule

// File: rtl/keypad_entry.sv
// Six-digit keypad entry: BCD buffer editing and serial BCD-to-binary commit.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_N = 16'd49_999,
  parameter logic [3:0]  DEB_N  = 4'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [19:0] bin,
  output logic [5:0]  dot,
  output logic        neg,
  output logic        valid,
  output logic        busy
);

  logic       key_evt;
  logic [3:0] key_code;

  key_scan #(
    .SCAN_N(SCAN_N),
    .DEB_N (DEB_N)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .row     (row),
    .col     (col),
    .key_evt (key_evt),
    .key_code(key_code)
  );

  entry_state_e st_q, st_d;
  logic [23:0] d_q, d_d;
  logic [2:0]  cnt_q, cnt_d, idx_q, idx_d;
  logic [5:0]  pm_q, pm_d, dot_q, dot_d;
  logic        sg_q, sg_d, neg_q, neg_d, valid_q, valid_d;
  logic [19:0] acc_q, acc_d, bin_q, bin_d;

  always_comb begin
    st_d    = st_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    pm_d    = pm_q;
    sg_d    = sg_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    bin_d   = bin_q;
    dot_d   = dot_q;
    neg_d   = neg_q;
    valid_d = 1'b0;
    unique case (st_q)
      StEntry: begin
        if (key_evt) begin
          if (key_code <= 4'd9) begin
            if (cnt_q != 3'd6) begin
              d_d   = {d_q[19:0], key_code};
              pm_d  = {pm_q[4:0], 1'b0};
              cnt_d = cnt_q + 3'd1;
            end
          end else begin
            case (key_code)
              KEY_DOT: if ((cnt_q != 3'd0) && (pm_q == 6'd0)) pm_d = 6'b000001;
              KEY_NEG: sg_d = ~sg_q;
              KEY_CLR: begin
                d_d   = '0;
                pm_d  = '0;
                cnt_d = '0;
                sg_d  = 1'b0;
              end
              KEY_BS: begin
                if (cnt_q != 3'd0) begin
                  d_d   = {4'h0, d_q[23:4]};
                  pm_d  = {1'b0, pm_q[5:1]};
                  cnt_d = cnt_q - 3'd1;
                end
              end
              KEY_ENT: begin
                st_d  = StConv;
                acc_d = '0;
                idx_d = '0;
              end
              default: ;
            endcase
          end
        end
      end
      StConv: begin
        // The buffer is cleared after commit anyway, so consume it MSD-first by shifting.
        acc_d = (acc_q << 3) + (acc_q << 1) + {16'd0, d_q[23:20]};
        d_d   = {d_q[19:0], 4'h0};
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd5) st_d = StDone;
      end
      StDone: begin
        bin_d   = acc_q;
        dot_d   = pm_q;
        neg_d   = sg_q && (acc_q != 20'd0);
        valid_d = 1'b1;
        d_d     = '0;
        pm_d    = '0;
        cnt_d   = '0;
        sg_d    = 1'b0;
        st_d    = StEntry;
      end
      default: st_d = StEntry;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= StEntry;
      d_q     <= '0;
      cnt_q   <= '0;
      pm_q    <= '0;
      sg_q    <= 1'b0;
      acc_q   <= '0;
      idx_q   <= '0;
      bin_q   <= '0;
      dot_q   <= '0;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      pm_q    <= pm_d;
      sg_q    <= sg_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      bin_q   <= bin_d;
      dot_q   <= dot_d;
      neg_q   <= neg_d;
      valid_q <= valid_d;
    end
  end

  assign bin   = bin_q;
  assign dot   = dot_q;
  assign neg   = neg_q;
  assign valid = valid_q;
  assign busy  = (st_q == StConv);

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a behavioural 4x4 matrix keypad model.
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row, col;
  logic [19:0] bin;
  logic [5:0]  dot;
  logic        neg, valid, busy;
  logic [15:0] pressed = '0;

  int checks = 0, passes = 0;
  int cyc = 0, evt_cnt = 0, valid_cnt = 0, busy_cnt = 0, ent_cyc = 0, valid_cyc = 0;

  keypad_entry #(
    .SCAN_N(16'd3),
    .DEB_N (4'd2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .row  (row),
    .col  (col),
    .bin  (bin),
    .dot  (dot),
    .neg  (neg),
    .valid(valid),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Pressed key k shorts row k/4 to column k%4.
  always_comb begin
    row = 4'hF;
    for (int k = 0; k < 16; k++) begin
      if (pressed[k] && !col[k % 4]) row[k / 4] = 1'b0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dut.key_evt) begin
      evt_cnt++;
      if (dut.key_code == 4'hE) ent_cyc = cyc;
    end
    if (valid) begin
      valid_cnt++;
      valid_cyc = cyc;
    end
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic press(input int k, input int idle);
    bit seen = 1'b0;
    pressed = 16'd1 << k;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (dut.key_evt) seen = 1'b1;
    end
    if (seen) check($sformatf("evt_code_%0d", k), 32'(dut.key_code), 32'(k));
    else check($sformatf("evt_timeout_%0d", k), 32'hDEAD, 32'(k));
    pressed = '0;
    repeat (idle) @(negedge clk);
  endtask

  int v0, b0, e0;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col", 32'(col), 32'hE);
    check("rst_bin", 32'(bin), 0);
    check("rst_dot", 32'(dot), 0);
    check("rst_neg", 32'(neg), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // 1,2,3,E
    press(1, 100); press(2, 100); press(3, 100);
    v0 = valid_cnt; b0 = busy_cnt;
    press(14, 100);
    check("t1_bin", 32'(bin), 123);
    check("t1_dot", 32'(dot), 0);
    check("t1_neg", 32'(neg), 0);
    check("t1_valid_pulses", 32'(valid_cnt - v0), 1);
    check("t1_valid_latency", 32'(valid_cyc - ent_cyc), 8);
    check("t1_busy_cycles", 32'(busy_cnt - b0), 6);

    // 1,A,5,B,E
    press(1, 100); press(10, 100); press(5, 100); press(11, 100); press(14, 100);
    check("t2_bin", 32'(bin), 15);
    check("t2_dot", 32'(dot), 32'h2);
    check("t2_neg", 32'(neg), 1);

    // 1..7,E: seventh digit dropped
    for (int k = 1; k <= 7; k++) press(k, 100);
    press(14, 100);
    check("t3_bin", 32'(bin), 123456);
    check("t3_neg", 32'(neg), 0);
    // B,E on empty buffer: minus zero is positive
    press(11, 100); press(14, 100);
    check("t3_zero_bin", 32'(bin), 0);
    check("t3_zero_neg", 32'(neg), 0);

    // 4,A,2,D,D,9,E
    press(4, 100); press(10, 100); press(2, 100); press(13, 100); press(13, 100);
    press(9, 100); press(14, 100);
    check("t4_bin", 32'(bin), 9);
    check("t4_dot", 32'(dot), 0);

    // 8,B,C,2,E: clear drops digits and sign
    press(8, 100); press(11, 100); press(12, 100); press(2, 100); press(14, 100);
    check("t5_bin", 32'(bin), 2);
    check("t5_neg", 32'(neg), 0);

    // One-frame glitch, then a two-key chord
    e0 = evt_cnt;
    pressed = 16'd1 << 3;
    repeat (16) @(negedge clk);
    pressed = '0;
    repeat (64) @(negedge clk);
    pressed = (16'd1 << 1) | (16'd1 << 6);
    repeat (160) @(negedge clk);
    pressed = '0;
    repeat (100) @(negedge clk);
    check("t6_no_evt", 32'(evt_cnt - e0), 0);

    // Hold 5 for 20 frames, then hold E through the conversion
    e0 = evt_cnt;
    pressed = 16'd1 << 5;
    repeat (320) @(negedge clk);
    pressed = '0;
    repeat (100) @(negedge clk);
    check("t6_hold_one_evt", 32'(evt_cnt - e0), 1);
    e0 = evt_cnt; v0 = valid_cnt;
    pressed = 16'd1 << 14;
    repeat (300) @(negedge clk);
    pressed = '0;
    repeat (100) @(negedge clk);
    check("t6_hold_ent_evt", 32'(evt_cnt - e0), 1);
    check("t6_hold_ent_valid", 32'(valid_cnt - v0), 1);
    check("t6_bin", 32'(bin), 5);

    // 1,B,E gives a nonzero negative commit before the reset test
    press(1, 100); press(11, 100); press(14, 100);
    check("t7_bin", 32'(bin), 1);
    check("t7_neg", 32'(neg), 1);

    // Reset during the 3rd CONV cycle of 9,9,E
    press(9, 100); press(9, 100);
    press(14, 0);
    repeat (3) @(negedge clk);
    check("t7_busy_conv3", 32'(busy), 1);
    v0 = valid_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("t7_rst_bin", 32'(bin), 0);
    check("t7_rst_col", 32'(col), 32'hE);
    check("t7_rst_neg", 32'(neg), 0);
    check("t7_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("t7_no_valid", 32'(valid_cnt - v0), 0);
    check("t7_bin_after", 32'(bin), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
